// File: rtl/frame_shape_color_detector.sv
// frame_shape_color_detector: per-frame red/blue band profile of the 176x144 image window,
// reduced at vsync to a dominant colour and coarse shape for the treasure-report pins.
module frame_shape_color_detector #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int BAND_H        = 48,
    parameter int R_MIN         = 5,
    parameter int B_MIN         = 2,
    parameter int MIN_PIXELS    = 400
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [1:0] COLOR,
    output logic [1:0] SHAPE,
    output logic       RESULT_VALID
);
    typedef enum logic [1:0] {ACCUM, COLOR_DEC, SHAPE_DEC, PUBLISH} state_t;

    localparam logic [9:0]  WIN_W   = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  WIN_H   = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]  BAND1_Y = 10'(BAND_H);
    localparam logic [9:0]  BAND2_Y = 10'(2 * BAND_H);
    localparam logic [2:0]  RED_MIN = 3'(R_MIN);
    localparam logic [1:0]  BLU_MIN = 2'(B_MIN);
    localparam logic [15:0] MIN_TOT = 16'(MIN_PIXELS);
    localparam logic [13:0] CNT_MAX = '1;

    state_t      state, state_n;
    logic [9:0]  y_d;
    logic        win_d;
    logic        vs_q, vs_p, fall;
    logic        first_frame;
    logic [1:0]  dom, shp, band;
    logic        is_red, is_blue;
    logic [13:0] red_cnt [3];
    logic [13:0] blue_cnt [3];
    logic [13:0] t, m, b;
    logic [15:0] rt, bt;

    // PIXEL_IN arrives one cycle after its coordinates, so pair it with the delayed ones
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_d   <= '0;
            win_d <= 1'b0;
            vs_q  <= 1'b1;
            vs_p  <= 1'b1;
        end else begin
            y_d   <= VGA_PIXEL_Y;
            win_d <= (VGA_PIXEL_X < WIN_W) && (VGA_PIXEL_Y < WIN_H);
            vs_q  <= VGA_VSYNC_NEG;
            vs_p  <= vs_q;
        end
    end

    assign fall    = vs_p & ~vs_q;
    assign is_red  = win_d && (PIXEL_IN[7:5] >= RED_MIN) && (PIXEL_IN[1:0] <= 2'd1);
    assign is_blue = win_d && (PIXEL_IN[1:0] >= BLU_MIN) && (PIXEL_IN[7:5] <= 3'd2);
    assign band    = (y_d < BAND1_Y) ? 2'd0 : (y_d < BAND2_Y) ? 2'd1 : 2'd2;
    assign rt      = 16'(red_cnt[0]) + 16'(red_cnt[1]) + 16'(red_cnt[2]);
    assign bt      = 16'(blue_cnt[0]) + 16'(blue_cnt[1]) + 16'(blue_cnt[2]);
    assign t       = (dom == 2'b10) ? blue_cnt[0] : red_cnt[0];
    assign m       = (dom == 2'b10) ? blue_cnt[1] : red_cnt[1];
    assign b       = (dom == 2'b10) ? blue_cnt[2] : red_cnt[2];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < 3; k++) begin
                red_cnt[k]  <= '0;
                blue_cnt[k] <= '0;
            end
        end else if (state == PUBLISH) begin
            for (int k = 0; k < 3; k++) begin
                red_cnt[k]  <= '0;
                blue_cnt[k] <= '0;
            end
        end else if (state == ACCUM) begin
            for (int k = 0; k < 3; k++) begin
                if (band == 2'(k) && is_red && red_cnt[k] != CNT_MAX)
                    red_cnt[k] <= red_cnt[k] + 14'd1;
                if (band == 2'(k) && is_blue && blue_cnt[k] != CNT_MAX)
                    blue_cnt[k] <= blue_cnt[k] + 14'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ACCUM;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = (state == ACCUM)     ? (fall ? COLOR_DEC : ACCUM) :
                  (state == COLOR_DEC) ? SHAPE_DEC :
                  (state == SHAPE_DEC) ? PUBLISH : ACCUM;
    end

    // the first publish after reset covers a partial frame, so it is suppressed
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dom          <= 2'b00;
            shp          <= 2'b00;
            COLOR        <= 2'b00;
            SHAPE        <= 2'b00;
            RESULT_VALID <= 1'b0;
            first_frame  <= 1'b1;
        end else begin
            RESULT_VALID <= (state == PUBLISH) && !first_frame;
            if (state == COLOR_DEC)
                dom <= (rt > bt && rt >= MIN_TOT) ? 2'b01 :
                       (bt > rt && bt >= MIN_TOT) ? 2'b10 : 2'b00;
            if (state == SHAPE_DEC)
                shp <= (dom == 2'b00)     ? 2'b00 :
                       (t < m && m < b)   ? 2'b01 :
                       (m > t && m > b)   ? 2'b10 : 2'b11;
            if (state == PUBLISH) begin
                if (!first_frame) begin
                    COLOR <= dom;
                    SHAPE <= shp;
                end
                first_frame <= 1'b0;
            end
        end
    end
endmodule
